sap_datapath: RTL and testbench

//  Executes the 15-bit control word issued each clock by the CPU Controller.

---
 rtl/sap_pkg.sv | 42 ++++
 rtl/sap_alu.sv | 21 ++
 rtl/sap_datapath.sv | 137 +++++++++++++
 tb/tb_sap_datapath.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 datapath: control-word bit positions, opcodes, default widths.
// No logic beyond one helper that flags more than one active bus driver.
package sap_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int CW_W       = 15;

    localparam int CW_J   = 0;
    localparam int CW_CO  = 1;
    localparam int CW_CE  = 2;
    localparam int CW_OI  = 3;
    localparam int CW_BI  = 4;
    localparam int CW_SU  = 5;
    localparam int CW_SO  = 6;
    localparam int CW_AO  = 7;
    localparam int CW_AI  = 8;
    localparam int CW_II  = 9;
    localparam int CW_IO  = 10;
    localparam int CW_RO  = 11;
    localparam int CW_RI  = 12;
    localparam int CW_MI  = 13;
    localparam int CW_HLT = 14;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // True when two or more of the bus-driver enables are set.
    function automatic logic multi_driver(input logic [4:0] drv);
        return (drv & (drv - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/sap_alu.sv
// SAP-1 adder/subtractor: purely combinational, zero latency, no flow control.
// Subtraction is A + ~B + 1, so carry_o means "no borrow".
module sap_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         su_i,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         zero_o
);

    logic [W:0] sum;

    assign sum      = {1'b0, a_i} + {1'b0, (su_i ? ~b_i : b_i)} + {{W{1'b0}}, su_i};
    assign result_o = sum[W-1:0];
    assign carry_o  = sum[W];
    assign zero_o   = (sum[W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: executes one control word per clock; bus and RAM read are combinational, loads land at the next edge.
// No backpressure: the controller's word is consumed every cycle, and ignored entirely once halted.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   ctrlwrd,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        instruction,
    output logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic              bus_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              carry_q, carry_d, zero_q, zero_d;
    logic              halted_q, halted_d, conflict_q, conflict_d;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic [DATA_W-1:0] alu_r;
    logic              alu_c, alu_z;
    logic [DATA_W-1:0] bus_val;
    logic [4:0]        drv;
    logic              run;

    sap_alu #(.W(DATA_W)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .su_i     (ctrlwrd[CW_SU]),
        .result_o (alu_r),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    assign run = !halted_q;
    assign drv = {ctrlwrd[CW_SO], ctrlwrd[CW_AO], ctrlwrd[CW_RO], ctrlwrd[CW_IO], ctrlwrd[CW_CO]};

    // Fixed priority SO > AO > RO > IO > CO; an idle bus reads as zero.
    always_comb begin
        bus_val = '0;
        if (ctrlwrd[CW_SO])      bus_val = alu_r;
        else if (ctrlwrd[CW_AO]) bus_val = a_q;
        else if (ctrlwrd[CW_RO]) bus_val = ram_q[mar_q];
        else if (ctrlwrd[CW_IO]) bus_val = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        else if (ctrlwrd[CW_CO]) bus_val = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end

    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        halted_d    = halted_q;
        conflict_d  = conflict_q;
        if (run) begin
            if (ctrlwrd[CW_MI]) mar_d = bus_val[ADDR_W-1:0];
            if (ctrlwrd[CW_II]) ir_d  = bus_val;
            if (ctrlwrd[CW_AI]) a_d   = bus_val;
            if (ctrlwrd[CW_BI]) b_d   = bus_val;
            if (ctrlwrd[CW_OI]) out_d = bus_val;
            out_valid_d = ctrlwrd[CW_OI];
            if (ctrlwrd[CW_J])       pc_d = bus_val[ADDR_W-1:0];
            else if (ctrlwrd[CW_CE]) pc_d = pc_q + ADDR_W'(1);
            if (ctrlwrd[CW_SO]) begin
                carry_d = alu_c;
                zero_d  = alu_z;
            end
            if (ctrlwrd[CW_HLT])    halted_d   = 1'b1;
            if (multi_driver(drv))  conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            halted_q    <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            halted_q    <= halted_d;
            conflict_q  <= conflict_d;
        end
    end

    // Program-load write is issued last so it overrides an RI to the same address.
    always_ff @(posedge clk) begin
        if (!reset && run && ctrlwrd[CW_RI]) ram_q[mar_q] <= bus_val;
        if (prog_we)                         ram_q[prog_addr] <= prog_data;
    end

    assign instruction  = ir_q[DATA_W-1:DATA_W-4];
    assign bus          = bus_val;
    assign pc           = pc_q;
    assign out_data     = out_q;
    assign out_valid    = out_valid_q;
    assign carry        = carry_q;
    assign zero         = zero_q;
    assign halted       = halted_q;
    assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: directed program fragments then random control words, all against an arithmetic reference model.
module tb_sap_datapath;

    localparam int J = 0, CO = 1, CE = 2, OI = 3, BI = 4, SU = 5, SO = 6, AO = 7;
    localparam int AI = 8, II = 9, IO = 10, RO = 11, RI = 12, MI = 13, HLT = 14;

    localparam logic [14:0] M_J  = 15'h0001, M_CO = 15'h0002, M_CE = 15'h0004, M_OI = 15'h0008;
    localparam logic [14:0] M_BI = 15'h0010, M_SU = 15'h0020, M_SO = 15'h0040, M_AO = 15'h0080;
    localparam logic [14:0] M_AI = 15'h0100, M_II = 15'h0200, M_IO = 15'h0400, M_RO = 15'h0800;
    localparam logic [14:0] M_RI = 15'h1000, M_MI = 15'h2000, M_HLT = 15'h4000;
    localparam logic [14:0] M_NONE = 15'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] ctrlwrd = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  instruction;
    logic [7:0]  bus;
    logic [3:0]  pc;
    logic [7:0]  out_data;
    logic        out_valid, carry, zero, halted, bus_conflict;

    int checks = 0;
    int errors = 0;

    int m_pc, m_mar, m_ir, m_a, m_b, m_out, m_ov, m_c, m_z, m_h, m_bc;
    int m_ram [16];

    always #5 clk = ~clk;

    sap_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .ctrlwrd      (ctrlwrd),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .instruction  (instruction),
        .bus          (bus),
        .pc           (pc),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .carry        (carry),
        .zero         (zero),
        .halted       (halted),
        .bus_conflict (bus_conflict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_bus(input logic [14:0] cw);
        if (cw[SO])      return cw[SU] ? (m_a - m_b + 256) % 256 : (m_a + m_b) % 256;
        else if (cw[AO]) return m_a;
        else if (cw[RO]) return m_ram[m_mar];
        else if (cw[IO]) return m_ir % 16;
        else if (cw[CO]) return m_pc;
        return 0;
    endfunction

    task automatic model_step(input logic [14:0] cw, input logic rst, input logic we,
                              input int wa, input int wd, input int b);
        int ndrv;
        ndrv = int'(cw[SO]) + int'(cw[AO]) + int'(cw[RO]) + int'(cw[IO]) + int'(cw[CO]);
        if (rst) begin
            m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
            m_ov = 0; m_c = 0; m_z = 0; m_h = 0; m_bc = 0;
        end else begin
            if (m_h == 0) begin
                if (ndrv > 1) m_bc = 1;
                if (cw[RI]) m_ram[m_mar] = b;
                if (cw[SO]) begin
                    m_c = cw[SU] ? int'(m_a >= m_b) : int'(m_a + m_b > 255);
                    m_z = int'(b == 0);
                end
                if (cw[J])       m_pc = b % 16;
                else if (cw[CE]) m_pc = (m_pc + 1) % 16;
                m_ov = int'(cw[OI]);
                if (cw[OI]) m_out = b;
                if (cw[MI]) m_mar = b % 16;
                if (cw[II]) m_ir = b;
                if (cw[AI]) m_a = b;
                if (cw[BI]) m_b = b;
                if (cw[HLT]) m_h = 1;
            end
            if (we) m_ram[wa] = wd;
        end
    endtask

    // One clock: drive, check the combinational bus mid-cycle, advance the model, check registers after the edge.
    task automatic cyc(input logic [14:0] cw, input logic rst, input logic we, input int wa, input int wd);
        int b;
        ctrlwrd   = cw;
        reset     = rst;
        prog_we   = we;
        prog_addr = wa[3:0];
        prog_data = wd[7:0];
        @(negedge clk);
        b = model_bus(cw);
        if (!rst) check("bus", bus, b);
        model_step(cw, rst, we, wa, wd, b);
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("instruction", instruction, m_ir / 16);
        check("out_data", out_data, m_out);
        check("out_valid", out_valid, m_ov);
        check("carry", carry, m_c);
        check("zero", zero, m_z);
        check("halted", halted, m_h);
        check("bus_conflict", bus_conflict, m_bc);
    endtask

    task automatic run(input logic [14:0] cw);
        cyc(cw, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic load(input int wa, input int wd);
        cyc(M_NONE, 1'b0, 1'b1, wa, wd);
    endtask

    initial begin
        logic [14:0] cw;
        logic        rst, we;
        int          sel, hcnt;
        for (int i = 0; i < 16; i++) m_ram[i] = 0;

        cyc(M_NONE, 1'b1, 1'b0, 0, 0);
        cyc(M_NONE, 1'b1, 1'b0, 0, 0);
        check("rst_pc", pc, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_conflict", bus_conflict, 0);
        check("rst_flags", {carry, zero}, 0);

        for (int i = 0; i < 16; i++) load(i, int'($urandom_range(0, 255)));
        load(14, 'h1C);
        load(15, 'h0E);
        load(0, 'h1E);

        // Fetch + LDA 14
        run(M_MI | M_CO);
        run(M_RO | M_II | M_CE);
        run(M_MI | M_IO);
        run(M_RO | M_AI);
        check("lda_pc", pc, 1);
        check("lda_instr", instruction, 1);
        run(M_AO);
        check("lda_a", bus, 'h1C);

        // Add, then subtract to zero
        run(M_IO | M_BI);
        run(M_SO | M_AI);
        check("add_flags", {carry, zero}, 2'b00);
        run(M_AO);
        check("add_a", bus, 'h2A);
        run(M_AO | M_BI);
        run(M_SO | M_SU | M_AI);
        check("sub_flags", {carry, zero}, 2'b11);
        run(M_AO);
        check("sub_a", bus, 'h00);

        // 0xFF + 1 overflow, PC wrap
        load(14, 'hFF);
        run(M_RO | M_AI);
        load(14, 'h01);
        run(M_RO | M_BI);
        run(M_SO | M_AI);
        check("ovf_flags", {carry, zero}, 2'b11);
        run(M_AO);
        check("ovf_a", bus, 'h00);
        load(14, 'h0F);
        run(M_RO | M_J);
        check("jmp_pc", pc, 15);
        run(M_CE);
        check("wrap_pc", pc, 0);

        // Jump beats increment; OUT pulse
        load(14, 'h63);
        run(M_RO | M_II);
        check("ir_op", instruction, 6);
        run(M_IO | M_J | M_CE);
        check("j_over_ce", pc, 3);
        load(14, 'h2A);
        run(M_RO | M_AI);
        run(M_AO | M_OI);
        check("out_data", out_data, 'h2A);
        check("out_pulse", out_valid, 1);
        run(M_NONE);
        check("out_pulse_end", out_valid, 0);

        // Halt freezes state
        run(M_HLT | M_AI);
        check("hlt_set", halted, 1);
        for (int i = 0; i < 5; i++) begin
            run(M_AO | M_OI | M_CE);
            check("hlt_pc", pc, 3);
            check("hlt_out", out_data, 'h2A);
            check("hlt_ov", out_valid, 0);
            check("hlt_a", bus, 0);
        end
        cyc(M_NONE, 1'b1, 1'b0, 0, 0);
        check("hlt_clear", halted, 0);

        // prog_we beats RI to the same address; conflict is sticky
        load(0, 'h05);
        run(M_RO | M_MI);
        cyc(M_AO | M_RI, 1'b0, 1'b1, 5, 'hA5);
        run(M_RO);
        check("prog_wins", bus, 'hA5);
        check("no_conflict", bus_conflict, 0);
        run(M_AO | M_CO);
        check("conflict_set", bus_conflict, 1);
        for (int i = 0; i < 3; i++) run(M_NONE);
        check("conflict_hold", bus_conflict, 1);
        cyc(M_NONE, 1'b1, 1'b0, 0, 0);
        check("conflict_clr", bus_conflict, 0);

        // Random control words
        hcnt = 0;
        for (int n = 0; n < 600; n++) begin
            cw  = 15'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel < 6) begin
                cw[SO] = 1'b0; cw[AO] = 1'b0; cw[RO] = 1'b0; cw[IO] = 1'b0; cw[CO] = 1'b0;
                case (sel)
                    0: cw[SO] = 1'b1;
                    1: cw[AO] = 1'b1;
                    2: cw[RO] = 1'b1;
                    3: cw[IO] = 1'b1;
                    4: cw[CO] = 1'b1;
                    default: ;
                endcase
            end
            cw[HLT] = ($urandom_range(0, 39) == 0);
            hcnt = (m_h != 0) ? hcnt + 1 : 0;
            rst  = ($urandom_range(0, 59) == 0) || (hcnt > 6);
            we   = !rst && ($urandom_range(0, 3) == 0);
            cyc(cw, rst, we, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
